data_mem_ctrl: RTL and testbench

Byte-addressable data memory for the RV32 datapath, replacing the single-cycle combinational data memory. It decodes Funct3 for all RV32I load/store widths, uses per-byte write strobes and byte-lane alignment, and sign- or zero-extends loads. Requests use a valid/ready handshake; responses come from a registered one-entry output stage with back-pressure. Misaligned or illegal-width accesses are trapped, not silently executed. The block sits between the execute stage (address = ALU result) and writeback.

---
 rtl/dmem_pkg.sv | 47 ++++
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/dmem_bank.sv | 26 ++
 rtl/data_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and access-legality helpers for the RV32 data memory controller.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 9;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_FCNT_W = 8;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

  // Unsigned widths exist only for loads.
  function automatic logic width_legal(input logic [2:0] funct3, input logic we);
    logic ok;
    ok = 1'b0;
    case (funct3_e'(funct3))
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (funct3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = !offset[0];
      2'b10:   ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response handshake bundle between execute stage and data memory.
interface data_mem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS  = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned FAULT_CNT_W = DMEM_FCNT_W
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [DM_ADDRESS-1:0]  req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic [2:0]             req_funct3;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_fault;
  logic [FAULT_CNT_W-1:0] fault_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, fault_count
  );
endinterface

// File: rtl/dmem_bank.sv
// Byte-strobed synchronous word RAM with one-cycle registered read.
module dmem_bank #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; rdata holds while re is low.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 data memory: load/store width decode, lane alignment, extension, fault trap.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS  = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned FAULT_CNT_W = DMEM_FCNT_W
) (
  input logic              clk,
  input logic              rst_n,
  data_mem_ctrl_if.slave   bus
);
  localparam int unsigned WORD_AW = DM_ADDRESS - 2;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("data_mem_ctrl supports DATA_W == 32 only");
  end

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic                   rsp_load_q, rsp_load_d;
  logic                   rsp_fault_q, rsp_fault_d;
  logic [2:0]             rsp_f3_q, rsp_f3_d;
  logic [1:0]             rsp_off_q, rsp_off_d;
  logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;

  logic                   rsp_valid;
  logic                   req_ready;
  logic                   accept_c;
  logic                   legal_c;
  logic                   rd_en_c;
  logic [1:0]             offset_c;
  logic [WORD_AW-1:0]     widx_c;
  logic [3:0]             wstrb_c;
  logic [DATA_W-1:0]      wlanes_c;
  logic [DATA_W-1:0]      bank_rdata;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [DATA_W-1:0]      ext_c;

  assign rsp_valid       = (state_q == S_RESP);
  assign req_ready       = !rsp_valid || bus.rsp_ready;
  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_fault   = rsp_fault_q;
  assign bus.fault_count = fcnt_q;
  assign bus.rsp_rdata   = rsp_load_q ? ext_c : '0;

  // Request decode: legality, byte strobes and lane-replicated store data.
  always_comb begin
    offset_c = bus.req_addr[1:0];
    widx_c   = bus.req_addr[DM_ADDRESS-1:2];
    accept_c = bus.req_valid && req_ready;
    legal_c  = width_legal(bus.req_funct3, bus.req_we) && is_aligned(bus.req_funct3, offset_c);
    wstrb_c  = 4'b1111;
    wlanes_c = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        wstrb_c  = 4'b0001 << offset_c;
        wlanes_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wstrb_c  = offset_c[1] ? 4'b1100 : 4'b0011;
        wlanes_c = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!(accept_c && bus.req_we && legal_c)) wstrb_c = 4'b0000;
    rd_en_c = accept_c && !bus.req_we && legal_c;
  end

  dmem_bank #(.AW(WORD_AW), .DW(DATA_W)) u_bank (
    .clk   (clk),
    .re    (rd_en_c),
    .we    (wstrb_c),
    .waddr (widx_c),
    .wdata (wlanes_c),
    .raddr (widx_c),
    .rdata (bank_rdata)
  );

  // Response FSM and metadata captured at acceptance.
  always_comb begin
    state_d     = state_q;
    rsp_load_d  = rsp_load_q;
    rsp_fault_d = rsp_fault_q;
    rsp_f3_d    = rsp_f3_q;
    rsp_off_d   = rsp_off_q;
    fcnt_d      = fcnt_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = accept_c ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept_c) begin
      rsp_load_d  = rd_en_c;
      rsp_fault_d = !legal_c;
      rsp_f3_d    = bus.req_funct3;
      rsp_off_d   = offset_c;
      if (!legal_c && (fcnt_q != '1)) fcnt_d = fcnt_q + FAULT_CNT_W'(1);
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_load_d  = 1'b0;
      rsp_fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rsp_load_q  <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_f3_q    <= 3'b000;
      rsp_off_q   <= 2'b00;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_load_q  <= rsp_load_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_f3_q    <= rsp_f3_d;
      rsp_off_q   <= rsp_off_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // Lane select and extension of the registered RAM word.
  always_comb begin
    case (rsp_off_q)
      2'd0:    lane_b = bank_rdata[7:0];
      2'd1:    lane_b = bank_rdata[15:8];
      2'd2:    lane_b = bank_rdata[23:16];
      default: lane_b = bank_rdata[31:24];
    endcase
    lane_h = rsp_off_q[1] ? bank_rdata[31:16] : bank_rdata[15:0];
    case (funct3_e'(rsp_f3_q))
      F3_B:    ext_c = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ext_c = {24'h000000, lane_b};
      F3_H:    ext_c = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ext_c = {16'h0000, lane_h};
      default: ext_c = bank_rdata;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: vector table replayed under steady and random back-pressure.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DM_ADDRESS(9), .DATA_W(32), .FAULT_CNT_W(8)) bus ();

  data_mem_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .FAULT_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    dmem_req_t   req;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] hold_rdata = '0;
  logic        hold_valid = 1'b0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_valid = 1'b0;
    end else begin
      if (bus.rsp_valid && hold_valid) chk("rdata_stable", bus.rsp_rdata, hold_rdata);
      hold_valid = bus.rsp_valid && !bus.rsp_ready;
      hold_rdata = bus.rsp_rdata;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: unexpected response rdata %h", bus.rsp_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
        end
      end
      if (bus.req_valid && bus.req_ready) sb.push_back(cur_exp);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic vec_t mk(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input logic [31:0] rd, input logic f);
    vec_t v;
    v.req.we     = we;
    v.req.addr   = addr;
    v.req.wdata  = wd;
    v.req.funct3 = f3;
    v.rdata      = rd;
    v.fault      = f;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = v.req.we;
    bus.req_addr   = v.req.addr;
    bus.req_wdata  = v.req.wdata;
    bus.req_funct3 = v.req.funct3;
    cur_exp.rdata  = v.rdata;
    cur_exp.fault  = v.fault;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_fault_count", 32'(bus.fault_count), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  vec_t tbl[$];
  int   nf;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.rsp_ready  = 1'b1;
    cur_exp        = '{32'd0, 1'b0};

    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(mk(1'b1, 9'h010, 32'hDEADBEEF, F3_W,  32'h00000000, 1'b0));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b0, 9'h013, 32'h0,        F3_B,  32'hFFFFFFDE, 1'b0));
    tbl.push_back(mk(1'b0, 9'h013, 32'h0,        F3_BU, 32'h000000DE, 1'b0));
    tbl.push_back(mk(1'b0, 9'h012, 32'h0,        F3_H,  32'hFFFFDEAD, 1'b0));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        F3_HU, 32'h0000BEEF, 1'b0));
    tbl.push_back(mk(1'b1, 9'h011, 32'hAAAAAA55, F3_B,  32'h00000000, 1'b0));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0));
    tbl.push_back(mk(1'b0, 9'h012, 32'h0,        F3_W,  32'h00000000, 1'b1));
    tbl.push_back(mk(1'b1, 9'h011, 32'h00001234, F3_H,  32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        3'b011, 32'h00000000, 1'b1));
    tbl.push_back(mk(1'b1, 9'h014, 32'h11223344, F3_W,  32'h00000000, 1'b0));
    tbl.push_back(mk(1'b1, 9'h016, 32'hA5A58001, F3_H,  32'h00000000, 1'b0));
    tbl.push_back(mk(1'b0, 9'h014, 32'h0,        F3_W,  32'h80013344, 1'b0));
    tbl.push_back(mk(1'b0, 9'h016, 32'h0,        F3_H,  32'hFFFF8001, 1'b0));
    tbl.push_back(mk(1'b0, 9'h014, 32'h0,        F3_HU, 32'h00003344, 1'b0));
    tbl.push_back(mk(1'b0, 9'h017, 32'h0,        F3_B,  32'hFFFFFF80, 1'b0));
    tbl.push_back(mk(1'b0, 9'h015, 32'h0,        F3_BU, 32'h00000033, 1'b0));
    tbl.push_back(mk(1'b0, 9'h016, 32'h0,        F3_BU, 32'h00000001, 1'b0));
    tbl.push_back(mk(1'b0, 9'h014, 32'h0,        F3_B,  32'h00000044, 1'b0));
    tbl.push_back(mk(1'b1, 9'h014, 32'h00000077, F3_BU, 32'h00000000, 1'b1));
    tbl.push_back(mk(1'b1, 9'h01A, 32'h12345678, F3_W,  32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h013, 32'h0,        F3_H,  32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h011, 32'h0,        F3_HU, 32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        3'b110, 32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h010, 32'h0,        3'b111, 32'h00000000, 1'b1));
    tbl.push_back(mk(1'b0, 9'h014, 32'h0,        F3_W,  32'h80013344, 1'b0));
    tbl.push_back(mk(1'b1, 9'h1FC, 32'h0BADF00D, F3_W,  32'h00000000, 1'b0));
    tbl.push_back(mk(1'b0, 9'h1FC, 32'h0,        F3_W,  32'h0BADF00D, 1'b0));
    tbl.push_back(mk(1'b0, 9'h1FF, 32'h0,        F3_B,  32'h0000000B, 1'b0));

    // Back-to-back pass with the consumer always ready.
    nf = 0;
    foreach (tbl[i]) begin
      issue(tbl[i]);
      if (tbl[i].fault) nf++;
    end
    bus.req_valid = 1'b0;
    drain();
    chk("fault_count_table", 32'(bus.fault_count), 32'(nf));

    // Five-cycle stall with a request waiting, then release.
    bus.rsp_ready = 1'b0;
    issue(mk(1'b0, 9'h010, 32'h0, F3_W, 32'hDEAD55EF, 1'b0));
    bus.req_addr   = 9'h014;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    cur_exp        = '{32'h80013344, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(mk(1'b0, 9'h016, 32'h0, F3_HU, 32'h00008001, 1'b0));
    bus.req_valid = 1'b0;
    drain();

    // Replay the table under random back-pressure.
    rand_rdy = 1'b1;
    foreach (tbl[i]) issue(tbl[i]);
    bus.req_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 bus.rsp_ready = 1'b1;
    drain();
    chk("fault_count_replay", 32'(bus.fault_count), 32'(2 * nf));

    repeat (300) issue(mk(1'b0, 9'h012, 32'h0, F3_W, 32'h00000000, 1'b1));
    bus.req_valid = 1'b0;
    drain();
    chk("fault_count_sat", 32'(bus.fault_count), 32'd255);

    // Reset with a store response pending; the store must persist.
    bus.rsp_ready = 1'b0;
    issue(mk(1'b1, 9'h020, 32'hCAFEF00D, F3_W, 32'h00000000, 1'b0));
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    issue(mk(1'b0, 9'h020, 32'h0, F3_W, 32'hCAFEF00D, 1'b0));
    bus.req_valid = 1'b0;
    drain();
    chk("post_rst_fault_count", 32'(bus.fault_count), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
